// File: rtl/if_stage_fetch.sv
// Instruction-fetch stage: issues word reads to instruction memory and presents
// fetched words (with pc+4) to the IF pipeline register, handling stalls and redirects.
module if_stage_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_address,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] instruction,
    output logic        valid
);

    localparam logic [1:0] ST_REQ  = 2'd0;
    localparam logic [1:0] ST_HOLD = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    logic [1:0]  r_st;
    logic [31:0] r_pc;
    logic [31:0] r_tgt;
    logic [31:0] r_buf;
    logic [31:0] w_pc_inc;
    logic [31:0] w_branch_tgt;

    assign w_pc_inc     = r_pc + 32'd4;
    assign w_branch_tgt = {branch_address[31:2], 2'b00};

    always_comb begin
        imem_req    = 1'b0;
        imem_addr   = r_pc;
        valid       = 1'b0;
        instruction = NOP_WORD;
        pc          = w_pc_inc;
        if (rst) begin
            pc = RESET_PC + 32'd4;
        end else begin
            case (r_st)
                ST_REQ: begin
                    imem_req = 1'b1;
                    // Zero-cycle bypass: the returning word goes straight out.
                    if (imem_ready && !branch_taken) begin
                        valid       = 1'b1;
                        instruction = imem_rdata;
                    end
                end
                ST_HOLD: begin
                    if (!branch_taken) begin
                        valid       = 1'b1;
                        instruction = r_buf;
                    end
                end
                ST_DROP: begin
                    imem_req = 1'b1;
                end
                default: begin
                    imem_req = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_st  <= ST_REQ;
            r_pc  <= RESET_PC;
            r_tgt <= RESET_PC;
            r_buf <= 32'd0;
        end else begin
            case (r_st)
                ST_REQ: begin
                    if (branch_taken) begin
                        if (imem_ready) begin
                            r_pc <= w_branch_tgt;
                        end else begin
                            // Request already in flight; let it finish before redirecting.
                            r_tgt <= w_branch_tgt;
                            r_st  <= ST_DROP;
                        end
                    end else if (imem_ready) begin
                        if (freeze) begin
                            r_buf <= imem_rdata;
                            r_st  <= ST_HOLD;
                        end else begin
                            r_pc <= w_pc_inc;
                        end
                    end
                end
                ST_HOLD: begin
                    if (branch_taken) begin
                        r_pc <= w_branch_tgt;
                        r_st <= ST_REQ;
                    end else if (!freeze) begin
                        r_pc <= w_pc_inc;
                        r_st <= ST_REQ;
                    end
                end
                ST_DROP: begin
                    if (branch_taken) begin
                        r_tgt <= w_branch_tgt;
                        if (imem_ready) begin
                            r_pc <= w_branch_tgt;
                            r_st <= ST_REQ;
                        end
                    end else if (imem_ready) begin
                        r_pc <= r_tgt;
                        r_st <= ST_REQ;
                    end
                end
                default: begin
                    r_st <= ST_REQ;
                end
            endcase
        end
    end

endmodule
